mem_port_arbiter: RTL and testbench

Shares the single byte-wide external memory port (MADDR/MWE/MD/MRDY) between two cache controllers: requester 0 (data side) and requester 1 (instruction side). Each requester locks the port for a whole multi-byte transaction. The arbiter picks round-robin between simultaneous requests and inserts a one-cycle bus turnaround between owners. A watchdog revokes the port from any owner that holds it too long.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared definitions for the external memory port arbiter.
//               Holds the arbiter state encoding and the default watchdog
//               limits.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter states: idle, owned by requester 0 or 1, bus turnaround
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } arb_state_t;

  // Default watchdog limit (cycles) and matching hold-counter width
  localparam int c_HOLD_MAX_DEFAULT = 64;
  localparam int c_CNT_W_DEFAULT    = 7;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin selector.
//               When both inputs are eligible, the one not served last wins.
// Ports       : i_elig  [1:0] eligibility vector (bit n = requester n)
//               i_last        index of the requester served last
//               o_pick  [1:0] one-hot pick (zero when nothing eligible)
//               o_valid       at least one requester eligible
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] i_elig,
  input  logic       i_last,
  output logic [1:0] o_pick,
  output logic       o_valid
);

  always_comb begin
    o_pick = i_elig;
    if (i_elig == 2'b11) begin
      // Tie: favour the requester that was not served last
      o_pick = i_last ? 2'b01 : 2'b10;
    end
    o_valid = |i_elig;
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one byte-wide external memory port between a data-side
//               (0) and an instruction-side (1) cache controller. Owners lock
//               the port per transaction; ties are resolved round-robin; a
//               one-cycle turnaround separates owners; a watchdog revokes
//               owners that hold the port for HOLD_MAX cycles.
// Ports       : CLK, RST (active-low, asynchronous assert)
//               REQ0/1, MADDR0/1, MWE0/1, MDO0/1   requester side inputs
//               GNT0/1, MRDY0/1, MDI, ERR[1:0]     requester side outputs
//               MADDR, MWE, MD (inout), MRDY       memory side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int HOLD_MAX = c_HOLD_MAX_DEFAULT,  // must be >= 8
  parameter int CNT_W    = c_CNT_W_DEFAULT      // 2**CNT_W > HOLD_MAX
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [31:0] MADDR0,
  input  logic [31:0] MADDR1,
  input  logic        MWE0,
  input  logic        MWE1,
  input  logic [7:0]  MDO0,
  input  logic [7:0]  MDO1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        MRDY0,
  output logic        MRDY1,
  output logic [7:0]  MDI,
  output logic [1:0]  ERR,
  output logic [31:0] MADDR,
  output logic        MWE,
  inout  wire  [7:0]  MD,
  input  logic        MRDY
);

  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       r_state;
  logic [1:0]       r_gnt;
  logic [1:0]       r_err;
  logic [1:0]       r_block;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_req;
  logic [1:0]       w_elig;
  logic [1:0]       w_pick;
  logic             w_pick_vld;
  logic             w_own_idx;
  logic [7:0]       w_mdo;

  assign w_req     = {REQ1, REQ0};
  // A revoked requester stays ineligible until it has dropped REQ once
  assign w_elig    = w_req & ~r_block;
  assign w_own_idx = (r_state == ST_OWN1);

  rr_pick2 u_pick (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  // --------------------------------------------------------------------------
  // Arbitration FSM, hold counter, BLOCK/LAST and registered grant/error
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_err   <= 2'b00;
      r_block <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_err   <= 2'b00;
      // Block clears the first time its REQ is seen low; a revoke below
      // only ever targets a requester whose REQ is high, so no conflict.
      r_block <= r_block & w_req;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_state <= w_pick[0] ? ST_OWN0 : ST_OWN1;
            r_gnt   <= w_pick;
            r_cnt   <= '0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (!w_req[w_own_idx]) begin
            // Normal release takes priority over a coincident watchdog hit
            r_state <= ST_TURN;
            r_gnt   <= 2'b00;
            r_last  <= w_own_idx;
          end else if (r_cnt == c_HOLD_LAST) begin
            r_state            <= ST_TURN;
            r_gnt              <= 2'b00;
            r_last             <= w_own_idx;
            r_err[w_own_idx]   <= 1'b1;
            r_block[w_own_idx] <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_TURN: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign GNT0 = r_gnt[0];
  assign GNT1 = r_gnt[1];
  assign ERR  = r_err;

  // --------------------------------------------------------------------------
  // Port muxes: the registered grant selects the owner; with no owner the
  // memory side is parked (address 0, read, bus released).
  // --------------------------------------------------------------------------
  always_comb begin
    MADDR = 32'h0;
    MWE   = 1'b0;
    w_mdo = 8'h00;
    MRDY0 = 1'b0;
    MRDY1 = 1'b0;
    if (r_gnt[0]) begin
      MADDR = MADDR0;
      MWE   = MWE0;
      w_mdo = MDO0;
      MRDY0 = MRDY;
    end else if (r_gnt[1]) begin
      MADDR = MADDR1;
      MWE   = MWE1;
      w_mdo = MDO1;
      MRDY1 = MRDY;
    end
  end

  assign MD  = MWE ? w_mdo : 8'bz;
  assign MDI = MD;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (HOLD_MAX=8).
//               Directed scenarios followed by randomized traffic, all
//               checked against a transaction-level ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int c_HOLD = 8;
  localparam int c_CW   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] maddr0, maddr1;
  logic        mwe0, mwe1;
  logic [7:0]  mdo0, mdo1;
  logic        gnt0, gnt1, mrdy0, mrdy1;
  logic [7:0]  mdi;
  logic [1:0]  err;
  logic [31:0] maddr;
  logic        mwe;
  logic        mrdy;
  logic [7:0]  mem_rd;
  wire  [7:0]  md;

  // Memory model drives the data bus whenever the port is not writing
  assign md = mwe ? 8'bz : mem_rd;

  always #5 clk = ~clk;

  mem_port_arbiter #(.HOLD_MAX(c_HOLD), .CNT_W(c_CW)) dut (
    .CLK(clk), .RST(rst_n),
    .REQ0(req0), .REQ1(req1),
    .MADDR0(maddr0), .MADDR1(maddr1),
    .MWE0(mwe0), .MWE1(mwe1),
    .MDO0(mdo0), .MDO1(mdo1),
    .GNT0(gnt0), .GNT1(gnt1),
    .MRDY0(mrdy0), .MRDY1(mrdy1),
    .MDI(mdi), .ERR(err),
    .MADDR(maddr), .MWE(mwe), .MD(md), .MRDY(mrdy)
  );

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  // Ownership model: who owns the port, how long, turnaround pending,
  // who was served last, who is blocked, which error pulse is showing.
  int       m_owner;
  int       m_gap;
  int       m_held;
  int       m_last;
  bit [1:0] m_blk;
  bit [1:0] m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 0;
    m_held  = 0;
    m_last  = 1;
    m_blk   = 2'b00;
    m_err   = 2'b00;
  endtask

  task automatic model_step(input bit r0, input bit r1);
    bit [1:0] rq;
    bit [1:0] el;
    rq    = {r1, r0};
    el    = rq & ~m_blk;
    m_err = 2'b00;
    m_blk = m_blk & rq;
    if (m_owner >= 0) begin
      if (!rq[m_owner[0]]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1;
      end else if (m_held + 1 >= c_HOLD) begin
        m_err[m_owner[0]] = 1'b1;
        m_blk[m_owner[0]] = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (el != 2'b00) begin
      if (el == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
      else             m_owner = el[1] ? 1 : 0;
      m_held = 0;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_addr;
    logic        e_we;
    logic [7:0]  e_d;
    e_addr = 32'h0;
    e_we   = 1'b0;
    e_d    = 8'h00;
    if (m_owner == 0) begin
      e_addr = maddr0; e_we = mwe0; e_d = mdo0;
    end else if (m_owner == 1) begin
      e_addr = maddr1; e_we = mwe1; e_d = mdo1;
    end
    chk("gnt0",  32'(gnt0),  32'(m_owner == 0));
    chk("gnt1",  32'(gnt1),  32'(m_owner == 1));
    chk("err",   32'(err),   32'(m_err));
    chk("maddr", maddr,      e_addr);
    chk("mwe",   32'(mwe),   32'(e_we));
    chk("mrdy0", 32'(mrdy0), 32'((m_owner == 0) && mrdy));
    chk("mrdy1", 32'(mrdy1), 32'((m_owner == 1) && mrdy));
    if (e_we) begin
      chk("md_wr",  32'(md),  32'(e_d));
      chk("mdi_wr", 32'(mdi), 32'(e_d));
    end else begin
      chk("mdi_rd", 32'(mdi), 32'(mem_rd));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(req0, req1);
    #1;
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset pulse asserted between clock edges
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    maddr0 = 32'h0; maddr1 = 32'h0;
    mwe0 = 1'b0; mwe1 = 1'b0;
    mdo0 = 8'h00; mdo1 = 8'h00;
    mrdy = 1'b0;
    mem_rd = 8'h3C;
    model_reset();
    #2 rst_n = 1'b0;

    // Reset state
    phase = "reset";
    cycles(2);
    rst_n = 1'b1;
    cycle();

    // Single write owner: address and data pass through, MRDY1 stays low
    phase = "write0";
    req0 = 1'b1; maddr0 = 32'h100; mwe0 = 1'b1; mdo0 = 8'hA5;
    cycle();
    chk("grant0_latency", 32'(gnt0), 32'd1);
    chk("md_a5", 32'(md), 32'h0A5);
    for (int i = 0; i < 3; i++) begin
      mrdy = (i != 1);
      cycle();
    end
    mrdy = 1'b0;
    req0 = 1'b0;
    cycles(2);
    mwe0 = 1'b0;
    cycle();

    // Tie after reset: 0 first, then 2 dead cycles before 1
    phase = "tie";
    do_reset();
    req0 = 1'b1; req1 = 1'b1; maddr1 = 32'h200;
    cycles(3);
    chk("tie_first0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    cycle();
    chk("dead1", 32'({gnt1, gnt0}), 32'd0);
    cycle();
    chk("dead2", 32'({gnt1, gnt0}), 32'd0);
    cycle();
    chk("tie_then1", 32'(gnt1), 32'd1);

    // Requester 1 four-byte read
    phase = "read1";
    for (int i = 0; i < 4; i++) begin
      maddr1 = 32'h200 + 32'(i);
      mem_rd = 8'($urandom);
      mrdy   = 1'b1;
      cycle();
    end
    mrdy = 1'b0;
    chk("read_hold", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    cycles(3);

    // Watchdog revoke with requester 1 waiting
    phase = "watchdog";
    req0 = 1'b1;
    cycle();
    req1 = 1'b1;
    cycles(7);
    chk("wd_still_own", 32'(gnt0), 32'd1);
    cycle();
    chk("wd_err", 32'(err), 32'h1);
    chk("wd_gnt0_drop", 32'(gnt0), 32'd0);
    cycle();
    chk("wd_err_pulse", 32'(err), 32'h0);
    cycle();
    chk("wd_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    cycles(3);
    chk("wd_blocked", 32'(gnt0), 32'd0);
    req0 = 1'b0;
    cycle();
    req0 = 1'b1;
    cycle();
    chk("wd_regrant", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    cycles(3);

    // Asynchronous reset in the middle of a write by requester 1
    phase = "rst_mid";
    req1 = 1'b1; mwe1 = 1'b1; mdo1 = 8'h5A; mrdy = 1'b1;
    cycles(2);
    chk("pre_rst_gnt1", 32'(gnt1), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_async_mwe", 32'(mwe), 32'd0);
    cycle();
    rst_n = 1'b1;
    req0 = 1'b1;
    cycle();
    chk("rst_tie0", 32'(gnt0), 32'd1);
    req0 = 1'b0; req1 = 1'b0; mwe1 = 1'b0; mrdy = 1'b0;
    cycles(3);

    // Release on the same edge the watchdog would fire
    phase = "wd_race";
    req0 = 1'b1;
    cycle();
    cycles(7);
    req0 = 1'b0;
    cycle();
    chk("race_no_err", 32'(err), 32'h0);
    req0 = 1'b1;
    cycles(2);
    chk("race_regrant", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    cycles(3);

    // Randomized traffic
    phase = "random";
    for (int n = 0; n < 1500; n++) begin
      if (req0) req0 = ($urandom_range(0, 7) != 0);
      else      req0 = ($urandom_range(0, 2) == 0);
      if (req1) req1 = ($urandom_range(0, 7) != 0);
      else      req1 = ($urandom_range(0, 2) == 0);
      maddr0 = $urandom;
      maddr1 = $urandom;
      mwe0   = 1'($urandom);
      mwe1   = 1'($urandom);
      mdo0   = 8'($urandom);
      mdo1   = 8'($urandom);
      mrdy   = 1'($urandom);
      mem_rd = 8'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else                             cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
